// File: rtl/sw_pkg.sv
// Shared definitions for the Smith-Waterman affine-gap PE: traceback codes,
// control states and the saturating score arithmetic.
package sw_pkg;

    localparam logic [1:0] TB_STOP = 2'b00;
    localparam logic [1:0] TB_DIAG = 2'b01;
    localparam logic [1:0] TB_UP   = 2'b10;
    localparam logic [1:0] TB_LEFT = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_READY = 2'b01,
        ST_RUN   = 2'b10
    } pe_state_e;

    // Scores up to this width are supported; narrower scores are zero-extended.
    localparam int SAT_MAX_W = 32;
    typedef logic [SAT_MAX_W-1:0] sat_word_t;

    // a +/- b clamped to [0, 2^w-1]; one extra bit carries the overflow/borrow.
    function automatic sat_word_t sat_addsub(input sat_word_t a, input sat_word_t b,
                                             input logic sub, input int unsigned w);
        logic [SAT_MAX_W:0] res_s;
        logic [SAT_MAX_W:0] lim_s;
        lim_s = {1'b0, {SAT_MAX_W{1'b1}}} >> (SAT_MAX_W - w);
        if (sub) begin
            res_s = {1'b0, a} - {1'b0, b};
            res_s = res_s[SAT_MAX_W] ? {(SAT_MAX_W+1){1'b0}} : res_s;
        end else begin
            res_s = {1'b0, a} + {1'b0, b};
            res_s = (res_s > lim_s) ? lim_s : res_s;
        end
        return res_s[SAT_MAX_W-1:0];
    endfunction

endpackage

// File: rtl/sw_score_cell.sv
// Combinational affine-gap cell: substitution, E/F gap scores, H and the
// traceback direction for one matrix cell.
module sw_score_cell
    import sw_pkg::*;
#(
    parameter int unsigned W        = 16,
    parameter int unsigned CW       = 3,
    parameter int unsigned MATCH    = 2,
    parameter int unsigned MISMATCH = 1,
    parameter int unsigned GAP_OPEN = 2,
    parameter int unsigned GAP_EXT  = 1
) (
    input  logic [CW-1:0] s_char,
    input  logic [CW-1:0] t_char,
    input  logic [W-1:0]  h_diag,
    input  logic [W-1:0]  h_left,
    input  logic [W-1:0]  e_prev,
    input  logic [W-1:0]  v_in,
    input  logic [W-1:0]  f_in,
    output logic [W-1:0]  e_new,
    output logic [W-1:0]  f_new,
    output logic [W-1:0]  h_new,
    output logic [1:0]    tb_code
);

    logic [W-1:0] ediag_s;
    logic [W-1:0] e_open_s;
    logic [W-1:0] e_ext_s;
    logic [W-1:0] f_open_s;
    logic [W-1:0] f_ext_s;

    // Candidate scores; H never drops below 0 because all scores are unsigned.
    always_comb begin
        ediag_s  = (s_char == t_char)
                 ? W'(sat_addsub(sat_word_t'(h_diag), sat_word_t'(MATCH), 1'b0, W))
                 : W'(sat_addsub(sat_word_t'(h_diag), sat_word_t'(MISMATCH), 1'b1, W));
        e_open_s = W'(sat_addsub(sat_word_t'(h_left), sat_word_t'(GAP_OPEN), 1'b1, W));
        e_ext_s  = W'(sat_addsub(sat_word_t'(e_prev), sat_word_t'(GAP_EXT), 1'b1, W));
        f_open_s = W'(sat_addsub(sat_word_t'(v_in), sat_word_t'(GAP_OPEN), 1'b1, W));
        f_ext_s  = W'(sat_addsub(sat_word_t'(f_in), sat_word_t'(GAP_EXT), 1'b1, W));
        e_new    = (e_open_s >= e_ext_s) ? e_open_s : e_ext_s;
        f_new    = (f_open_s >= f_ext_s) ? f_open_s : f_ext_s;
        h_new    = ediag_s;
        if (f_new > h_new) begin
            h_new = f_new;
        end else begin
            h_new = h_new;
        end
        if (e_new > h_new) begin
            h_new = e_new;
        end else begin
            h_new = h_new;
        end
    end

    // Traceback priority on ties: diagonal, then up (F), then left (E).
    always_comb begin
        if (h_new == {W{1'b0}}) begin
            tb_code = TB_STOP;
        end else if (h_new == ediag_s) begin
            tb_code = TB_DIAG;
        end else if (h_new == f_new) begin
            tb_code = TB_UP;
        end else begin
            tb_code = TB_LEFT;
        end
    end

endmodule

// File: rtl/sw_pe_affine.sv
// Smith-Waterman affine-gap systolic PE: one query character per PE, streams
// target characters, tracks the running best score and its column.
module sw_pe_affine
    import sw_pkg::*;
#(
    parameter int unsigned W        = 16,
    parameter int unsigned CW       = 3,
    parameter int unsigned CNT_W    = 10,
    parameter int unsigned MATCH    = 2,
    parameter int unsigned MISMATCH = 1,
    parameter int unsigned GAP_OPEN = 2,
    parameter int unsigned GAP_EXT  = 1
) (
    input  logic             clk,
    input  logic             reset_ni,
    input  logic             load_i,
    input  logic [CW-1:0]    s_i,
    output logic [CW-1:0]    s_o,
    input  logic [CW-1:0]    t_i,
    output logic [CW-1:0]    t_o,
    input  logic             t_valid_i,
    output logic             t_valid_o,
    input  logic             t_last_i,
    output logic             t_last_o,
    input  logic [W-1:0]     v_i,
    output logic [W-1:0]     v_o,
    input  logic [W-1:0]     f_i,
    output logic [W-1:0]     f_o,
    input  logic [W-1:0]     max_i,
    output logic [W-1:0]     max_o,
    input  logic [CNT_W-1:0] pos_i,
    output logic [CNT_W-1:0] pos_o,
    output logic [1:0]       tb_o,
    output logic             tb_valid_o
);

    localparam logic [CNT_W-1:0] COL_MAX = {CNT_W{1'b1}};

    pe_state_e        state_r, state_nxt_s;
    logic [CW-1:0]    s_reg_r;
    logic [W-1:0]     h_left_r, e_r, h_diag_r, best_r;
    logic [CNT_W-1:0] col_r, best_pos_r;

    logic             beat_s, start_s, load_ok_s;
    logic [W-1:0]     h_left_s, e_prev_s, h_diag_s, best_s;
    logic [CNT_W-1:0] col_s, best_pos_s;
    logic [W-1:0]     e_new_s, f_new_s, h_new_s;
    logic [1:0]       tb_new_s;
    logic [W-1:0]     best_nxt_s, max_nxt_s;
    logic [CNT_W-1:0] best_pos_nxt_s, pos_nxt_s, col_nxt_s;

    // A run's first beat sees cleared row state instead of the previous run's.
    always_comb begin
        beat_s     = t_valid_i && (state_r != ST_IDLE);
        start_s    = (state_r == ST_READY);
        load_ok_s  = load_i && (state_r != ST_RUN);
        h_left_s   = start_s ? {W{1'b0}} : h_left_r;
        e_prev_s   = start_s ? {W{1'b0}} : e_r;
        h_diag_s   = start_s ? {W{1'b0}} : h_diag_r;
        best_s     = start_s ? {W{1'b0}} : best_r;
        col_s      = start_s ? {CNT_W{1'b0}} : col_r;
        best_pos_s = start_s ? {CNT_W{1'b0}} : best_pos_r;
    end

    sw_score_cell #(
        .W(W), .CW(CW), .MATCH(MATCH), .MISMATCH(MISMATCH),
        .GAP_OPEN(GAP_OPEN), .GAP_EXT(GAP_EXT)
    ) u_cell (
        .s_char (s_reg_r),
        .t_char (t_i),
        .h_diag (h_diag_s),
        .h_left (h_left_s),
        .e_prev (e_prev_s),
        .v_in   (v_i),
        .f_in   (f_i),
        .e_new  (e_new_s),
        .f_new  (f_new_s),
        .h_new  (h_new_s),
        .tb_code(tb_new_s)
    );

    // Local best keeps the first column reaching it; upstream wins ties.
    always_comb begin
        if (h_new_s > best_s) begin
            best_nxt_s     = h_new_s;
            best_pos_nxt_s = col_s;
        end else begin
            best_nxt_s     = best_s;
            best_pos_nxt_s = best_pos_s;
        end
        if ((max_i >= h_new_s) && (max_i >= best_nxt_s)) begin
            max_nxt_s = max_i;
            pos_nxt_s = pos_i;
        end else begin
            max_nxt_s = best_nxt_s;
            pos_nxt_s = best_pos_nxt_s;
        end
        col_nxt_s = (col_s == COL_MAX) ? col_s : col_s + {{(CNT_W-1){1'b0}}, 1'b1};
    end

    // Control FSM next state.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE:  state_nxt_s = load_i ? ST_READY : ST_IDLE;
            ST_READY: state_nxt_s = (t_valid_i && !t_last_i) ? ST_RUN : ST_READY;
            ST_RUN:   state_nxt_s = (t_valid_i && t_last_i) ? ST_READY : ST_RUN;
            default:  state_nxt_s = ST_IDLE;
        endcase
    end

    // State, row registers and outputs; an IDLE PE forwards its inputs.
    always_ff @(posedge clk or negedge reset_ni) begin
        if (!reset_ni) begin
            state_r    <= ST_IDLE;
            s_reg_r    <= '0;
            h_left_r   <= '0;
            e_r        <= '0;
            h_diag_r   <= '0;
            col_r      <= '0;
            best_r     <= '0;
            best_pos_r <= '0;
            s_o        <= '0;
            t_o        <= '0;
            t_valid_o  <= 1'b0;
            t_last_o   <= 1'b0;
            v_o        <= '0;
            f_o        <= '0;
            max_o      <= '0;
            pos_o      <= '0;
            tb_o       <= 2'b00;
            tb_valid_o <= 1'b0;
        end else begin
            state_r    <= state_nxt_s;
            t_o        <= t_i;
            t_valid_o  <= t_valid_i;
            t_last_o   <= t_last_i;
            tb_valid_o <= beat_s;
            if (load_ok_s) begin
                s_o     <= s_reg_r;
                s_reg_r <= s_i;
            end
            if (beat_s) begin
                h_left_r   <= h_new_s;
                e_r        <= e_new_s;
                h_diag_r   <= v_i;
                col_r      <= col_nxt_s;
                best_r     <= best_nxt_s;
                best_pos_r <= best_pos_nxt_s;
                v_o        <= h_new_s;
                f_o        <= f_new_s;
                max_o      <= max_nxt_s;
                pos_o      <= pos_nxt_s;
                tb_o       <= tb_new_s;
            end else if (t_valid_i) begin
                v_o   <= v_i;
                f_o   <= f_i;
                max_o <= max_i;
                pos_o <= pos_i;
            end
        end
    end

endmodule

// File: tb/tb_sw_pe_affine.sv
// Self-checking bench for sw_pe_affine: directed vectors, hand sequences and
// randomized stimulus against a score-matrix reference model.
module tb_sw_pe_affine;

    localparam int W = 16, CW = 3, CNT_W = 10;
    localparam int MAXV = 65535, COLMAX = 1023;

    logic clk = 1'b0;
    logic reset_ni;
    logic load_i, t_valid_i, t_last_i;
    logic [CW-1:0] s_i, t_i, s_o, t_o;
    logic t_valid_o, t_last_o, tb_valid_o;
    logic [W-1:0] v_i, f_i, max_i, v_o, f_o, max_o;
    logic [CNT_W-1:0] pos_i, pos_o;
    logic [1:0] tb_o;

    logic load2, tv2, tl2, tv2_o, tl2_o, tbv2_o;
    logic [CW-1:0] s2, t2, s2_o, t2_o;
    logic [3:0] v2, f2, m2, v2_o, f2_o, m2_o;
    logic [CNT_W-1:0] p2, p2_o;
    logic [1:0] tb2_o;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    sw_pe_affine dut (
        .clk(clk), .reset_ni(reset_ni), .load_i(load_i), .s_i(s_i), .s_o(s_o),
        .t_i(t_i), .t_o(t_o), .t_valid_i(t_valid_i), .t_valid_o(t_valid_o),
        .t_last_i(t_last_i), .t_last_o(t_last_o), .v_i(v_i), .v_o(v_o),
        .f_i(f_i), .f_o(f_o), .max_i(max_i), .max_o(max_o), .pos_i(pos_i),
        .pos_o(pos_o), .tb_o(tb_o), .tb_valid_o(tb_valid_o)
    );

    sw_pe_affine #(.W(4)) dut_w4 (
        .clk(clk), .reset_ni(reset_ni), .load_i(load2), .s_i(s2), .s_o(s2_o),
        .t_i(t2), .t_o(t2_o), .t_valid_i(tv2), .t_valid_o(tv2_o),
        .t_last_i(tl2), .t_last_o(tl2_o), .v_i(v2), .v_o(v2_o),
        .f_i(f2), .f_o(f2_o), .max_i(m2), .max_o(m2_o), .pos_i(p2),
        .pos_o(p2_o), .tb_o(tb2_o), .tb_valid_o(tbv2_o)
    );

    typedef struct {
        logic [2:0]  t;
        logic        tv;
        logic        tl;
        logic [15:0] v;
        logic [15:0] exp_v;
        logic [1:0]  exp_tb;
        logic [15:0] exp_max;
        logic [9:0]  exp_pos;
        logic        exp_tbv;
    } vec_t;

    // Reference model state: the matrix row seen by one query character.
    bit m_loaded, m_run;
    int m_s, m_hl, m_e, m_hd, m_col, m_best, m_bpos;
    logic [15:0] e_v, e_f, e_max;
    logic [9:0]  e_pos;
    logic [1:0]  e_tb;
    logic        e_tbv, e_tv, e_tl;
    logic [2:0]  e_s_o, e_t;

    function automatic int clamp(input int x);
        return (x < 0) ? 0 : ((x > MAXV) ? MAXV : x);
    endfunction

    function automatic int imax(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic clr_in();
        load_i = 1'b0; s_i = '0; t_i = '0; t_valid_i = 1'b0; t_last_i = 1'b0;
        v_i = '0; f_i = '0; max_i = '0; pos_i = '0;
    endtask

    task automatic model_reset();
        m_loaded = 0; m_run = 0; m_s = 0; m_hl = 0; m_e = 0; m_hd = 0;
        m_col = 0; m_best = 0; m_bpos = 0;
        e_v = '0; e_f = '0; e_max = '0; e_pos = '0; e_tb = '0; e_tbv = 1'b0;
        e_tv = 1'b0; e_tl = 1'b0; e_s_o = '0; e_t = '0;
    endtask

    // Predicts the registered outputs produced by the coming clock edge.
    task automatic model_step();
        int sub, ed, ee, ff, h;
        bit do_load;
        do_load = load_i && !m_run;
        e_t = t_i; e_tv = t_valid_i; e_tl = t_last_i;
        e_tbv = t_valid_i && m_loaded;
        if (t_valid_i && !m_loaded) begin
            e_v = v_i; e_f = f_i; e_max = max_i; e_pos = pos_i;
        end else if (t_valid_i) begin
            if (!m_run) begin
                m_hl = 0; m_e = 0; m_hd = 0; m_col = 0; m_best = 0; m_bpos = 0;
            end
            sub = (m_s == int'(t_i)) ? 2 : -1;
            ed = clamp(m_hd + sub);
            ee = imax(clamp(m_hl - 2), clamp(m_e - 1));
            ff = imax(clamp(int'(v_i) - 2), clamp(int'(f_i) - 1));
            h  = imax(imax(0, ed), imax(ee, ff));
            e_tb = (h == 0) ? 2'b00 : (h == ed) ? 2'b01 : (h == ff) ? 2'b10 : 2'b11;
            if (h > m_best) begin
                m_best = h; m_bpos = m_col;
            end
            if (int'(max_i) >= h && int'(max_i) >= m_best) begin
                e_max = max_i; e_pos = pos_i;
            end else begin
                e_max = 16'(m_best); e_pos = 10'(m_bpos);
            end
            e_v = 16'(h); e_f = 16'(ff);
            m_hl = h; m_e = ee; m_hd = int'(v_i);
            m_col = (m_col < COLMAX) ? m_col + 1 : COLMAX;
            m_run = !t_last_i;
        end
        if (do_load) begin
            e_s_o = 3'(m_s); m_s = int'(s_i); m_loaded = 1;
        end
    endtask

    task automatic rand_cycle(input int tag);
        model_step();
        step();
        chk($sformatf("rand%0d", tag),
            {v_o, f_o, max_o, pos_o, tb_o, tb_valid_o, s_o, t_o, t_valid_o, t_last_o},
            {e_v, e_f, e_max, e_pos, e_tb, e_tbv, e_s_o, e_t, e_tv, e_tl});
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[10];
        vecs[0] = '{3'd1, 1'b1, 1'b0, 16'd4, 16'd2, 2'b01, 16'd2, 10'd0, 1'b1};
        vecs[1] = '{3'd1, 1'b1, 1'b0, 16'd0, 16'd6, 2'b01, 16'd6, 10'd1, 1'b1};
        vecs[2] = '{3'd2, 1'b1, 1'b0, 16'd0, 16'd4, 2'b11, 16'd6, 10'd1, 1'b1};
        vecs[3] = '{3'd2, 1'b1, 1'b0, 16'd0, 16'd3, 2'b11, 16'd6, 10'd1, 1'b1};
        vecs[4] = '{3'd2, 1'b1, 1'b1, 16'd0, 16'd2, 2'b11, 16'd6, 10'd1, 1'b1};
        vecs[5] = '{3'd1, 1'b1, 1'b0, 16'd0, 16'd2, 2'b01, 16'd2, 10'd0, 1'b1};
        vecs[6] = '{3'd2, 1'b1, 1'b1, 16'd0, 16'd0, 2'b00, 16'd2, 10'd0, 1'b1};
        vecs[7] = '{3'd1, 1'b1, 1'b0, 16'd0, 16'd2, 2'b01, 16'd2, 10'd0, 1'b1};
        vecs[8] = '{3'd0, 1'b0, 1'b0, 16'd0, 16'd2, 2'b01, 16'd2, 10'd0, 1'b0};
        vecs[9] = '{3'd2, 1'b1, 1'b1, 16'd0, 16'd0, 2'b00, 16'd2, 10'd0, 1'b1};

        clr_in();
        load2 = 1'b0; s2 = '0; t2 = '0; tv2 = 1'b0; tl2 = 1'b0;
        v2 = '0; f2 = '0; m2 = '0; p2 = '0;
        reset_ni = 1'b0;
        #12;
        chk("reset_outputs",
            {v_o, f_o, max_o, pos_o, tb_o, tb_valid_o, s_o, t_o, t_valid_o, t_last_o}, 128'd0);
        reset_ni = 1'b1;
        step();

        t_valid_i = 1'b1; v_i = 16'd7; f_i = 16'd1; max_i = 16'd7; pos_i = 10'd3;
        step();
        chk("idle_pass", {v_o, f_o, max_o, pos_o, tb_valid_o},
            {16'd7, 16'd1, 16'd7, 10'd3, 1'b0});

        clr_in(); load_i = 1'b1; s_i = 3'd1;
        step();
        chk("load_s_o", {29'd0, s_o}, 32'd0);
        clr_in();

        t_i = 3'd1; t_valid_i = 1'b1; t_last_i = 1'b1;
        step();
        chk("single_match", {v_o, tb_o, max_o, pos_o, f_o, tb_valid_o},
            {16'd2, 2'b01, 16'd2, 10'd0, 16'd0, 1'b1});

        v_i = 16'd9; max_i = 16'd7; pos_i = 10'd3;
        step();
        chk("tie_upstream", {v_o, tb_o, max_o, pos_o}, {16'd7, 2'b10, 16'd7, 10'd3});
        clr_in();

        for (int i = 0; i < 10; i++) begin
            t_i = vecs[i].t; t_valid_i = vecs[i].tv; t_last_i = vecs[i].tl; v_i = vecs[i].v;
            step();
            chk($sformatf("vec%0d", i), {v_o, tb_o, max_o, pos_o, tb_valid_o},
                {vecs[i].exp_v, vecs[i].exp_tb, vecs[i].exp_max, vecs[i].exp_pos, vecs[i].exp_tbv});
        end

        clr_in(); t_i = 3'd1; t_valid_i = 1'b1; v_i = 16'd3;
        step();
        #2 reset_ni = 1'b0;
        #1;
        chk("async_reset",
            {v_o, f_o, max_o, pos_o, tb_o, tb_valid_o, s_o, t_o, t_valid_o, t_last_o}, 128'd0);
        clr_in();
        step();
        reset_ni = 1'b1;
        t_valid_i = 1'b1; v_i = 16'd5;
        step();
        chk("post_reset_pass", {v_o, tb_valid_o}, {16'd5, 1'b0});
        clr_in();

        load2 = 1'b1; s2 = 3'd1;
        step();
        load2 = 1'b0; t2 = 3'd1; tv2 = 1'b1; v2 = 4'd14;
        step();
        chk("w4_first", {v2_o, tb2_o}, {4'd12, 2'b10});
        v2 = 4'd0; tl2 = 1'b1;
        step();
        chk("w4_saturate", {v2_o, tb2_o}, {4'd15, 2'b01});
        tv2 = 1'b0; tl2 = 1'b0;

        reset_ni = 1'b0;
        model_reset();
        step();
        reset_ni = 1'b1;
        for (int i = 0; i < 800; i++) begin
            t_valid_i = ($urandom % 4) != 0;
            t_last_i  = ($urandom % 6) == 0;
            load_i    = !t_valid_i && (($urandom % 3) == 0);
            s_i       = 3'($urandom_range(0, 3));
            t_i       = 3'($urandom_range(0, 3));
            v_i       = (($urandom % 8) == 0) ? 16'($urandom_range(65500, 65535)) : 16'($urandom_range(0, 12));
            f_i       = (($urandom % 8) == 0) ? 16'($urandom_range(65500, 65535)) : 16'($urandom_range(0, 12));
            max_i     = 16'($urandom_range(0, 15));
            pos_i     = 10'($urandom);
            rand_cycle(i);
        end

        clr_in(); load_i = 1'b1; s_i = 3'd2;
        rand_cycle(800);
        for (int k = 0; k < 1100; k++) begin
            clr_in();
            t_valid_i = 1'b1; t_last_i = (k == 1099);
            t_i = 3'($urandom_range(0, 3));
            v_i = 16'(10 * k);
            rand_cycle(801 + k);
        end
        clr_in();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
